// File: rtl/crono_countdown.sv
// BCD hh:mm:ss countdown engine: loads from the setter, decrements once per tick,
// and holds an alarm for a bounded number of ticks once the count reaches zero.
module crono_countdown #(
    parameter int unsigned TICK_DIV   = 100_000_000,
    parameter int unsigned ALARM_SECS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       EN_CFG,
    input  logic [7:0] HCcr,
    input  logic [7:0] MCcr,
    input  logic [7:0] SCcr,
    input  logic       BTstart,
    input  logic       BTclr,
    output logic [7:0] HCnt,
    output logic [7:0] MCnt,
    output logic [7:0] SCnt,
    output logic       running,
    output logic       alarm
);
    localparam int unsigned DW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned AW = (ALARM_SECS > 1) ? $clog2(ALARM_SECS) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(TICK_DIV - 1);
    localparam logic [AW-1:0] ALM_MAX = AW'(ALARM_SECS - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, ALARM} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [AW-1:0] alm_q, alm_d;
    logic [23:0]   cnt_q, cnt_d;
    logic          start_ref_q, clr_ref_q;
    logic          start_edge, clr_edge, tick;
    logic [23:0]   load_val, dec_val;

    function automatic logic [7:0] ms_ok(input logic [7:0] v);
        return (v[7:4] > 4'd5 || v[3:0] > 4'd9) ? 8'h00 : v;
    endfunction

    function automatic logic [7:0] hr_ok(input logic [7:0] v);
        return (v[7:4] > 4'd2 || v[3:0] > 4'd9 || (v[7:4] == 4'd2 && v[3:0] > 4'd3)) ? 8'h00 : v;
    endfunction

    // Ripple a single borrow from seconds units up to hours tens.
    function automatic logic [23:0] bcd_dec(input logic [23:0] c);
        logic [23:0] r;
        logic        b;
        r = c;
        b = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (b) begin
                if (r[i*4 +: 4] == 4'd0) r[i*4 +: 4] = (i % 2 == 1) ? 4'd5 : 4'd9;
                else begin
                    r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        if (b && r[23:20] != 4'd0) r[23:20] = r[23:20] - 4'd1;
        return r;
    endfunction

    assign start_edge = BTstart & ~start_ref_q;
    assign clr_edge   = BTclr & ~clr_ref_q;
    assign load_val   = {hr_ok(HCcr), ms_ok(MCcr), ms_ok(SCcr)};
    assign dec_val    = bcd_dec(cnt_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            div_q       <= '0;
            alm_q       <= '0;
            cnt_q       <= '0;
            start_ref_q <= 1'b0;
            clr_ref_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            alm_q       <= alm_d;
            cnt_q       <= cnt_d;
            start_ref_q <= BTstart;
            clr_ref_q   <= BTclr;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        alm_d   = alm_q;
        cnt_d   = cnt_q;
        tick    = 1'b0;
        if (state_q == RUN || state_q == ALARM) begin
            if (div_q == DIV_MAX) begin
                div_d = '0;
                tick  = 1'b1;
            end else begin
                div_d = div_q + 1'b1;
            end
        end
        case (state_q)
            IDLE: begin
                div_d = '0;
                if (EN_CFG || clr_edge) cnt_d = load_val;
                else if (start_edge && cnt_q != 24'h0) state_d = RUN;
            end
            RUN: begin
                if (EN_CFG) state_d = IDLE;
                else if (clr_edge) begin
                    cnt_d   = load_val;
                    div_d   = '0;
                    state_d = IDLE;
                end else begin
                    if (tick) cnt_d = dec_val;
                    if (tick && dec_val == 24'h0) begin
                        state_d = ALARM;
                        alm_d   = '0;
                    end else if (start_edge) begin
                        state_d = PAUSE;
                    end
                end
            end
            PAUSE: begin
                if (EN_CFG) state_d = IDLE;
                else if (clr_edge) begin
                    cnt_d   = load_val;
                    div_d   = '0;
                    state_d = IDLE;
                end else if (start_edge) state_d = RUN;
            end
            ALARM: begin
                if (EN_CFG) state_d = IDLE;
                else if (clr_edge) begin
                    cnt_d   = load_val;
                    div_d   = '0;
                    state_d = IDLE;
                end else if (start_edge) state_d = IDLE;
                else if (tick) begin
                    if (alm_q == ALM_MAX) state_d = IDLE;
                    else alm_d = alm_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        HCnt    = cnt_q[23:16];
        MCnt    = cnt_q[15:8];
        SCnt    = cnt_q[7:0];
        running = (state_q == RUN);
        alarm   = (state_q == ALARM);
    end
endmodule

// File: tb/tb_crono_countdown.sv
// Directed bench: stimulus queues timestamped expected outputs; a monitor pops one
// entry per observed output change and checks both value and cycle.
module tb_crono_countdown;
    logic       clk = 1'b0;
    logic       reset, EN_CFG, BTstart, BTclr;
    logic [7:0] HCcr, MCcr, SCcr;
    logic [7:0] HCnt, MCnt, SCnt;
    logic       running, alarm;

    crono_countdown #(.TICK_DIV(4), .ALARM_SECS(3)) dut (
        .clk(clk), .reset(reset), .EN_CFG(EN_CFG),
        .HCcr(HCcr), .MCcr(MCcr), .SCcr(SCcr),
        .BTstart(BTstart), .BTclr(BTclr),
        .HCnt(HCnt), .MCnt(MCnt), .SCnt(SCnt),
        .running(running), .alarm(alarm)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [25:0] val;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          nchk = 0;
    int          npass = 0;
    bit          mon_en = 1'b0;
    logic [25:0] prev = '0;

    task automatic expect_at(input int c, input logic [7:0] h, input logic [7:0] m,
                             input logic [7:0] s, input logic r, input logic a);
        exp_t e;
        e.cyc = c;
        e.val = {h, m, s, r, a};
        q.push_back(e);
    endtask

    task automatic tk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: any output change must match the next queued expectation.
    always begin
        logic [25:0] cur;
        exp_t        e;
        @(posedge clk);
        #1;
        cyc++;
        cur = {HCnt, MCnt, SCnt, running, alarm};
        if (mon_en && cur !== prev) begin
            nchk++;
            if (q.size() == 0) begin
                $display("FAIL unexpected_change cyc=%0d got %h:%h:%h run=%b alm=%b",
                         cyc, cur[25:18], cur[17:10], cur[9:2], cur[1], cur[0]);
            end else begin
                e = q.pop_front();
                if (cur === e.val && cyc == e.cyc) npass++;
                else
                    $display("FAIL out_change got cyc=%0d %h:%h:%h run=%b alm=%b, want cyc=%0d %h:%h:%h run=%b alm=%b",
                             cyc, cur[25:18], cur[17:10], cur[9:2], cur[1], cur[0],
                             e.cyc, e.val[25:18], e.val[17:10], e.val[9:2], e.val[1], e.val[0]);
            end
        end
        prev = cur;
    end

    initial begin
        int b;
        reset = 1'b1; EN_CFG = 1'b0; BTstart = 1'b0; BTclr = 1'b0;
        HCcr = 8'h00; MCcr = 8'h00; SCcr = 8'h00;
        tk(2);
        nchk++;
        if ({HCnt, MCnt, SCnt, running, alarm} === 26'h0) npass++;
        else $display("FAIL reset_state got %h:%h:%h run=%b alm=%b want 00:00:00 0 0",
                      HCnt, MCnt, SCnt, running, alarm);
        reset = 1'b0;
        mon_en = 1'b1;

        // Illegal hours alone clear only the hours; illegal min/sec load as zero.
        b = cyc;
        expect_at(b+1, 8'h00, 8'h15, 8'h30, 1'b0, 1'b0);
        expect_at(b+2, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        EN_CFG = 1'b1; HCcr = 8'h24; MCcr = 8'h15; SCcr = 8'h30;
        tk(1);
        HCcr = 8'h00; MCcr = 8'h7A; SCcr = 8'h65;
        tk(1);
        EN_CFG = 1'b0; BTstart = 1'b1;
        tk(10);
        BTstart = 1'b0;
        tk(1);
        nchk++;
        if (running === 1'b0 && {HCnt, MCnt, SCnt} === 24'h0) npass++;
        else $display("FAIL zero_start_ignored got run=%b %h:%h:%h want run=0 00:00:00",
                      running, HCnt, MCnt, SCnt);

        // 00:00:03 countdown into alarm, alarm auto-clears after 3 ticks.
        b = cyc;
        expect_at(b+1,  8'h00, 8'h00, 8'h03, 1'b0, 1'b0);
        expect_at(b+2,  8'h00, 8'h00, 8'h03, 1'b1, 1'b0);
        expect_at(b+6,  8'h00, 8'h00, 8'h02, 1'b1, 1'b0);
        expect_at(b+10, 8'h00, 8'h00, 8'h01, 1'b1, 1'b0);
        expect_at(b+14, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
        expect_at(b+26, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        EN_CFG = 1'b1; HCcr = 8'h00; MCcr = 8'h00; SCcr = 8'h03;
        tk(1);
        EN_CFG = 1'b0; BTstart = 1'b1;
        tk(3);
        BTstart = 1'b0;
        tk(b + 28 - cyc);

        // Borrow across minutes/hours: 01:00:00 and 00:10:00.
        b = cyc;
        expect_at(b+1,  8'h01, 8'h00, 8'h00, 1'b0, 1'b0);
        expect_at(b+2,  8'h01, 8'h00, 8'h00, 1'b1, 1'b0);
        expect_at(b+6,  8'h00, 8'h59, 8'h59, 1'b1, 1'b0);
        expect_at(b+7,  8'h00, 8'h10, 8'h00, 1'b0, 1'b0);
        expect_at(b+8,  8'h00, 8'h10, 8'h00, 1'b1, 1'b0);
        expect_at(b+12, 8'h00, 8'h09, 8'h59, 1'b1, 1'b0);
        EN_CFG = 1'b1; HCcr = 8'h01; MCcr = 8'h00; SCcr = 8'h00;
        tk(1);
        EN_CFG = 1'b0; BTstart = 1'b1;
        tk(1);
        BTstart = 1'b0;
        tk(4);
        HCcr = 8'h00; MCcr = 8'h10; SCcr = 8'h00; BTclr = 1'b1;
        tk(1);
        BTclr = 1'b0; BTstart = 1'b1;
        tk(1);
        BTstart = 1'b0;
        tk(4);

        // Pause two clocks into a second; the partial second survives.
        b = cyc;
        expect_at(b+2,  8'h00, 8'h09, 8'h59, 1'b0, 1'b0);
        expect_at(b+23, 8'h00, 8'h09, 8'h59, 1'b1, 1'b0);
        expect_at(b+25, 8'h00, 8'h09, 8'h58, 1'b1, 1'b0);
        expect_at(b+26, 8'h00, 8'h00, 8'h02, 1'b0, 1'b0);
        tk(1);
        BTstart = 1'b1;
        tk(1);
        BTstart = 1'b0;
        tk(20);
        BTstart = 1'b1;
        tk(1);
        BTstart = 1'b0;
        tk(2);
        HCcr = 8'h00; MCcr = 8'h00; SCcr = 8'h02; BTclr = 1'b1;
        tk(1);
        BTclr = 1'b0;

        // BTclr during ALARM reloads and returns to IDLE.
        b = cyc;
        expect_at(b+1,  8'h00, 8'h00, 8'h02, 1'b1, 1'b0);
        expect_at(b+5,  8'h00, 8'h00, 8'h01, 1'b1, 1'b0);
        expect_at(b+9,  8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
        expect_at(b+11, 8'h12, 8'h34, 8'h56, 1'b0, 1'b0);
        BTstart = 1'b1;
        tk(1);
        BTstart = 1'b0;
        tk(9);
        HCcr = 8'h12; MCcr = 8'h34; SCcr = 8'h56; BTclr = 1'b1;
        tk(1);
        BTclr = 1'b0;

        // Tick with BTstart: decrement then pause; reload; reset mid-run at 00:01:30.
        b = cyc;
        expect_at(b+1,  8'h12, 8'h34, 8'h56, 1'b1, 1'b0);
        expect_at(b+5,  8'h12, 8'h34, 8'h55, 1'b0, 1'b0);
        expect_at(b+7,  8'h00, 8'h01, 8'h30, 1'b0, 1'b0);
        expect_at(b+8,  8'h00, 8'h01, 8'h30, 1'b1, 1'b0);
        expect_at(b+11, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        BTstart = 1'b1;
        tk(1);
        BTstart = 1'b0;
        tk(3);
        BTstart = 1'b1;
        tk(1);
        BTstart = 1'b0;
        tk(1);
        HCcr = 8'h00; MCcr = 8'h01; SCcr = 8'h30; BTclr = 1'b1;
        tk(1);
        BTclr = 1'b0; BTstart = 1'b1;
        tk(1);
        BTstart = 1'b0;
        tk(2);
        reset = 1'b1;
        tk(1);
        reset = 1'b0;

        // BTclr beats BTstart in the same cycle.
        b = cyc;
        expect_at(b+1, 8'h00, 8'h00, 8'h05, 1'b0, 1'b0);
        HCcr = 8'h00; MCcr = 8'h00; SCcr = 8'h05; BTclr = 1'b1; BTstart = 1'b1;
        tk(1);
        BTclr = 1'b0; BTstart = 1'b0;
        tk(1);

        // Hours units borrow from tens; EN_CFG aborts RUN, then loads in IDLE.
        b = cyc;
        expect_at(b+1, 8'h10, 8'h00, 8'h00, 1'b0, 1'b0);
        expect_at(b+2, 8'h10, 8'h00, 8'h00, 1'b1, 1'b0);
        expect_at(b+6, 8'h09, 8'h59, 8'h59, 1'b1, 1'b0);
        expect_at(b+7, 8'h09, 8'h59, 8'h59, 1'b0, 1'b0);
        expect_at(b+8, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        HCcr = 8'h10; MCcr = 8'h00; SCcr = 8'h00; BTclr = 1'b1;
        tk(1);
        BTclr = 1'b0; BTstart = 1'b1;
        tk(1);
        BTstart = 1'b0;
        tk(4);
        EN_CFG = 1'b1; HCcr = 8'h00; MCcr = 8'h00; SCcr = 8'h00;
        tk(2);
        EN_CFG = 1'b0;
        tk(3);

        nchk++;
        if (q.size() == 0) npass++;
        else $display("FAIL pending_expectations got %0d left want 0", q.size());
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
